// File: rtl/meas_spi_pkg.sv
// Shared types and constants for the host-side measurement SPI reader.
package meas_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_GAP      = 3'd3,
        ST_CS_HOLD  = 3'd4,
        ST_CS_GUARD = 3'd5
    } spi_state_e;

    // Opcode decoded by the slave-side main_ctrl as "read measurement count".
    localparam logic [7:0] CMD_READ_MEAS = 8'hA3;
    localparam int MEAS_BYTES = 3;
    localparam int MEAS_W     = 24;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/meas_spi_master_sck_gen.sv
// SCK divider: toggles spi_clk every CLK_DIV cycles while enabled, with edge strobes
// that coincide with the clk edge that performs the toggle.
module spi_sck_gen
    import meas_spi_pkg::*;
#(
    parameter int CLK_DIV = 6
) (
    input  logic clk_12mhz,
    input  logic rst_n,
    input  logic en,
    output logic spi_clk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_r;
    logic             tc_s;

    assign tc_s     = en && (div_cnt_r == DIV_W'(CLK_DIV - 1));
    assign rise_stb = tc_s && !spi_clk;
    assign fall_stb = tc_s && spi_clk;

    // Half-period counter and SCK register; both park at zero when disabled.
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            spi_clk   <= 1'b0;
        end else if (!en) begin
            div_cnt_r <= {DIV_W{1'b0}};
            spi_clk   <= 1'b0;
        end else if (tc_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            spi_clk   <= ~spi_clk;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/meas_spi_master.sv
// Host-side SPI mode-0 master: sends one command byte, then reads NUM_BYTES data
// bytes (LSB byte first) and presents them as one word with a one-cycle strobe.
module meas_spi_master
    import meas_spi_pkg::*;
#(
    parameter int CLK_DIV   = 6,
    parameter int GAP_CYC   = 12,
    parameter int CS_IDLE   = 6,
    parameter int NUM_BYTES = MEAS_BYTES
) (
    input  logic                   clk_12mhz,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             cmd,
    output logic                   busy,
    output logic [8*NUM_BYTES-1:0] data_out,
    output logic                   data_valid,
    output logic                   spi_cs,
    output logic                   spi_clk,
    output logic                   spi_mosi,
    input  logic                   spi_miso
);

    localparam int CYC_W = $clog2(max3(CLK_DIV, GAP_CYC, CS_IDLE) + 1);
    localparam int BC_W  = $clog2(NUM_BYTES + 1);

    spi_state_e             state_r;
    logic [CYC_W-1:0]       cyc_cnt_r;
    logic [3:0]             bit_cnt_r;
    logic [BC_W-1:0]        byte_cnt_r;
    logic [6:0]             tx_sr_r;
    logic [7:0]             rx_sr_r;
    logic [8*NUM_BYTES-1:0] stage_r;
    logic                   rise_stb_s;
    logic                   fall_stb_s;
    logic                   accept_s;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk_12mhz (clk_12mhz),
        .rst_n     (rst_n),
        .en        (state_r == ST_SHIFT),
        .spi_clk   (spi_clk),
        .rise_stb  (rise_stb_s),
        .fall_stb  (fall_stb_s)
    );

    // A start held through the last guard cycle is taken on that edge, so
    // back-to-back reads lose no extra cycle in IDLE.
    assign accept_s = start && ((state_r == ST_IDLE) ||
                      ((state_r == ST_CS_GUARD) && (cyc_cnt_r == CYC_W'(CS_IDLE - 1))));

    // Transaction sequencer, shift registers, staging and output registers.
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cyc_cnt_r  <= {CYC_W{1'b0}};
            bit_cnt_r  <= 4'd0;
            byte_cnt_r <= {BC_W{1'b0}};
            tx_sr_r    <= 7'd0;
            rx_sr_r    <= 8'd0;
            stage_r    <= {(8*NUM_BYTES){1'b0}};
            spi_cs     <= 1'b1;
            spi_mosi   <= 1'b0;
            busy       <= 1'b0;
            data_out   <= {(8*NUM_BYTES){1'b0}};
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (accept_s) begin
                state_r    <= ST_CS_SETUP;
                cyc_cnt_r  <= {CYC_W{1'b0}};
                bit_cnt_r  <= 4'd0;
                byte_cnt_r <= {BC_W{1'b0}};
                tx_sr_r    <= cmd[6:0];
                rx_sr_r    <= 8'd0;
                stage_r    <= {(8*NUM_BYTES){1'b0}};
                spi_cs     <= 1'b0;
                spi_mosi   <= cmd[7];
                busy       <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        cyc_cnt_r <= {CYC_W{1'b0}};
                    end
                    ST_CS_SETUP: begin
                        if (cyc_cnt_r == CYC_W'(CLK_DIV - 1)) begin
                            cyc_cnt_r <= {CYC_W{1'b0}};
                            state_r   <= ST_SHIFT;
                        end else begin
                            cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                        end
                    end
                    ST_SHIFT: begin
                        if (rise_stb_s) begin
                            rx_sr_r <= {rx_sr_r[6:0], spi_miso};
                        end
                        if (fall_stb_s) begin
                            if (bit_cnt_r == 4'd7) begin
                                // Byte done; every byte after the command shifts out zeros.
                                bit_cnt_r <= 4'd0;
                                tx_sr_r   <= 7'd0;
                                spi_mosi  <= 1'b0;
                                for (int i = 0; i < NUM_BYTES; i++) begin
                                    if (byte_cnt_r == BC_W'(i + 1)) begin
                                        stage_r[8*i +: 8] <= rx_sr_r;
                                    end
                                end
                                if (byte_cnt_r == BC_W'(NUM_BYTES)) begin
                                    byte_cnt_r <= {BC_W{1'b0}};
                                    state_r    <= ST_CS_HOLD;
                                end else begin
                                    byte_cnt_r <= byte_cnt_r + BC_W'(1);
                                    state_r    <= ST_GAP;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                                tx_sr_r   <= {tx_sr_r[5:0], 1'b0};
                                spi_mosi  <= tx_sr_r[6];
                            end
                        end
                    end
                    ST_GAP: begin
                        if (cyc_cnt_r == CYC_W'(GAP_CYC - 1)) begin
                            cyc_cnt_r <= {CYC_W{1'b0}};
                            state_r   <= ST_SHIFT;
                        end else begin
                            cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                        end
                    end
                    ST_CS_HOLD: begin
                        if (cyc_cnt_r == CYC_W'(CLK_DIV - 1)) begin
                            cyc_cnt_r  <= {CYC_W{1'b0}};
                            state_r    <= ST_CS_GUARD;
                            spi_cs     <= 1'b1;
                            data_out   <= stage_r;
                            data_valid <= 1'b1;
                        end else begin
                            cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                        end
                    end
                    ST_CS_GUARD: begin
                        if (cyc_cnt_r == CYC_W'(CS_IDLE - 1)) begin
                            cyc_cnt_r <= {CYC_W{1'b0}};
                            state_r   <= ST_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        cyc_cnt_r <= {CYC_W{1'b0}};
                        spi_cs    <= 1'b1;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_meas_spi_master.sv
// Directed bench for meas_spi_master: slave models with a 3-flop SCK synchroniser,
// data_valid events checked against a scoreboard of expected (cycle, word) pairs.
module tb_meas_spi_master;

    localparam int CLK_DIV = 6;
    localparam int GAP_CYC = 12;
    localparam int CS_IDLE = 6;
    localparam int T_A     = 432;
    localparam int T_B     = 300;

    typedef struct {
        int          dut;
        int          cyc;
        logic [23:0] val;
    } ev_t;

    logic        clk_12mhz = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [7:0]  cmd;
    logic        busy_a, dv_a, cs_a, sck_a, mosi_a, miso_a;
    logic        busy_b, dv_b, cs_b, sck_b, mosi_b, miso_b;
    logic [23:0] dout_a, dout_b;

    always #5 clk_12mhz = ~clk_12mhz;

    meas_spi_master #(.CLK_DIV(6), .GAP_CYC(12), .CS_IDLE(6), .NUM_BYTES(3)) dut_a (
        .clk_12mhz(clk_12mhz), .rst_n(rst_n), .start(start_a), .cmd(cmd),
        .busy(busy_a), .data_out(dout_a), .data_valid(dv_a), .spi_cs(cs_a),
        .spi_clk(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a));

    meas_spi_master #(.CLK_DIV(4), .GAP_CYC(12), .CS_IDLE(6), .NUM_BYTES(3)) dut_b (
        .clk_12mhz(clk_12mhz), .rst_n(rst_n), .start(start_b), .cmd(cmd),
        .busy(busy_b), .data_out(dout_b), .data_valid(dv_b), .spi_cs(cs_b),
        .spi_clk(sck_b), .spi_mosi(mosi_b), .spi_miso(miso_b));

    // Slave models: SCK passes a 3-flop synchroniser; MISO advances on the synced fall.
    logic [23:0] resp_a = 24'h0, resp_b = 24'h0;
    int          mode_a = 0;
    int          idx_a = 0, idx_b = 0;
    logic [2:0]  sync_a = 3'b000, sync_b = 3'b000;

    function automatic logic slave_bit(input logic [23:0] r, input int idx);
        int b;
        if (idx < 8 || idx >= 32) return 1'b0;
        b = idx - 8;
        return r[8*(b/8) + 7 - (b%8)];
    endfunction

    always @(posedge clk_12mhz) begin
        sync_a <= {sync_a[1:0], sck_a};
        if (cs_a) idx_a <= 0;
        else if (sync_a[2] && !sync_a[1]) idx_a <= idx_a + 1;
    end

    always @(posedge clk_12mhz) begin
        sync_b <= {sync_b[1:0], sck_b};
        if (cs_b) idx_b <= 0;
        else if (sync_b[2] && !sync_b[1]) idx_b <= idx_b + 1;
    end

    always_comb begin
        miso_a = slave_bit(resp_a, idx_a);
        if (mode_a == 1) miso_a = 1'b1;
        if (mode_a == 2) miso_a = 1'b0;
        miso_b = slave_bit(resp_b, idx_b);
    end

    // Bench state: all of it is written only from the initial block below.
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0;
    ev_t         exp_q[$], obs_q[$];
    logic [31:0] mosi_word = 32'h0;
    int          first_rise = -1;
    logic        prev_cs_a = 1'b1, prev_sck_a = 1'b0;
    int          cs_hi_run = 0, cs_hi_min = 100000, sck_lo_run = 0, gap_max = 0;
    logic        seen_low = 1'b0;
    int          e0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        ev_t ev;
        @(negedge clk_12mhz);
        cyc++;
        if (dv_a) begin ev.dut = 0; ev.cyc = cyc; ev.val = dout_a; obs_q.push_back(ev); end
        if (dv_b) begin ev.dut = 1; ev.cyc = cyc; ev.val = dout_b; obs_q.push_back(ev); end
        if (!cs_a && prev_cs_a) begin mosi_word = 32'h0; first_rise = -1; end
        if (sck_a && !prev_sck_a) begin
            mosi_word = {mosi_word[30:0], mosi_a};
            if (first_rise < 0) first_rise = cyc;
        end
        if (cs_a) cs_hi_run++;
        else begin
            if (seen_low && cs_hi_run > 0 && cs_hi_run < cs_hi_min) cs_hi_min = cs_hi_run;
            cs_hi_run = 0;
            seen_low  = 1'b1;
        end
        // SCK-low runs while selected; the inter-byte one spans the gap plus one half-period.
        if (!cs_a && !sck_a) sck_lo_run++;
        else begin
            if (sck_lo_run > gap_max) gap_max = sck_lo_run;
            sck_lo_run = 0;
        end
        prev_cs_a  = cs_a;
        prev_sck_a = sck_a;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check_sb();
        ev_t e, o;
        chk("sb_count", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk("dv_dut", o.dut, e.dut);
            chk("dv_cycle", o.cyc, e.cyc);
            chk("data_out", {8'h0, o.val}, {8'h0, e.val});
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic push_exp(input int dut, input int at, input logic [23:0] v);
        ev_t ev;
        ev.dut = dut; ev.cyc = at; ev.val = v;
        exp_q.push_back(ev);
    endtask

    initial begin
        rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0; cmd = 8'hA3;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_cs", cs_a, 1); chk("rst_sck", sck_a, 0); chk("rst_mosi", mosi_a, 0);
        chk("rst_busy", busy_a, 0); chk("rst_dv", dv_a, 0); chk("rst_dout", dout_a, 0);
        chk("rst_cs_b", cs_b, 1);
        rst_n = 1'b1;
        repeat (2) tick();

        // Reset in the middle of data byte 2: immediate return to idle levels, no strobe.
        resp_a = 24'h654321; mode_a = 0;
        start_a = 1'b1; tick(); e0 = cyc; start_a = 1'b0;
        chk("accept_cs", cs_a, 0); chk("accept_busy", busy_a, 1);
        run_to(e0 + 255);
        chk("mid_sck_high", sck_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs", cs_a, 1); chk("arst_sck", sck_a, 0);
        chk("arst_busy", busy_a, 0); chk("arst_dout", dout_a, 0);
        tick(); rst_n = 1'b1;
        run_to(cyc + 500);
        chk("arst_no_dv", obs_q.size(), 0); chk("arst_dout_after", dout_a, 0);
        obs_q.delete();

        // Basic read: 0x56, 0x34, 0x12 from the slave.
        resp_a = 24'h123456;
        start_a = 1'b1; tick(); e0 = cyc; start_a = 1'b0;
        push_exp(0, e0 + T_A, 24'h123456);
        chk("basic_cs_low", cs_a, 0);
        run_to(e0 + T_A - 1); chk("cs_before_T", cs_a, 0);
        tick();               chk("cs_at_T", cs_a, 1);
        run_to(e0 + T_A + CS_IDLE - 1); chk("busy_before_fall", busy_a, 1);
        tick();                         chk("busy_fall", busy_a, 0);
        run_to(e0 + T_A + 10);
        chk("first_rise", first_rise, e0 + 2*CLK_DIV);
        chk("mosi_bytes", mosi_word, 32'hA300_0000);
        check_sb();

        // MISO stuck high; data_out must hold the previous word mid-transfer.
        mode_a = 1;
        start_a = 1'b1; tick(); e0 = cyc; start_a = 1'b0;
        push_exp(0, e0 + T_A, 24'hFFFFFF);
        run_to(e0 + 300); chk("partial_hold", dout_a, 24'h123456);
        run_to(e0 + T_A + 10);
        check_sb();

        // MISO stuck low.
        mode_a = 2;
        start_a = 1'b1; tick(); e0 = cyc; start_a = 1'b0;
        push_exp(0, e0 + T_A, 24'h000000);
        run_to(e0 + T_A + 10);
        check_sb();

        // Start pulsed again while busy: ignored, not queued.
        mode_a = 0; resp_a = 24'hABCDEF;
        start_a = 1'b1; tick(); e0 = cyc; start_a = 1'b0;
        push_exp(0, e0 + T_A, 24'hABCDEF);
        run_to(e0 + 99); start_a = 1'b1; tick(); start_a = 1'b0;
        run_to(e0 + T_A + CS_IDLE - 1); chk("ign_busy_hi", busy_a, 1);
        tick();                         chk("ign_busy_lo", busy_a, 0);
        run_to(e0 + 600);
        chk("ign_cs_idle", cs_a, 1);
        check_sb();

        // Back-to-back with start held high.
        resp_a = 24'h0F1E2D;
        cs_hi_run = 0; cs_hi_min = 100000; seen_low = 1'b0; sck_lo_run = 0; gap_max = 0;
        start_a = 1'b1; tick(); e0 = cyc;
        push_exp(0, e0 + T_A, 24'h0F1E2D);
        push_exp(0, e0 + T_A + CS_IDLE + T_A, 24'h0F1E2D);
        run_to(e0 + T_A + CS_IDLE - 1); chk("b2b_cs_high", cs_a, 1);
        tick();                         chk("b2b_cs_fall", cs_a, 0);
        start_a = 1'b0;
        run_to(e0 + T_A + CS_IDLE + T_A + 10);
        chk("b2b_cs_hi_min", cs_hi_min, CS_IDLE);
        chk("b2b_gap", gap_max, GAP_CYC + CLK_DIV);
        check_sb();

        // CLK_DIV=4 instance with the lagging slave.
        resp_b = 24'hA5C3E1;
        start_b = 1'b1; tick(); e0 = cyc; start_b = 1'b0;
        chk("b_cs_low", cs_b, 0);
        push_exp(1, e0 + T_B, 24'hA5C3E1);
        run_to(e0 + T_B + 10);
        check_sb();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
